// File: rtl/accum_frame4.sv
// Frame accumulator: sums a stream of unsigned beats until in_last, then holds
// the total (with sticky overflow and saturating beat count) until taken.
module accum_frame4 #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic               run_q;
  logic               accept;
  logic               done;
  logic [ACC_W-1:0]   in_ext;
  logic [ACC_W:0]     sum;

  assign in_ext = ACC_W'(in_data);
  assign sum    = {1'b0, acc} + {1'b0, in_ext};

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state_q)
      ACC: begin
        // run_q keeps the input closed until the first edge after reset release
        in_ready = run_q && !clr;
        accept   = in_valid && in_ready;
        if (accept && in_last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        done      = out_ready;
        if (done) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  // cnt == 0 doubles as the frame-start marker since it saturates and never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (done || (state_q == ACC && clr)) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        if (cnt == '0) begin
          acc <= in_ext;
          ovf <= 1'b0;
        end else begin
          acc <= sum[ACC_W-1:0];
          ovf <= ovf | sum[ACC_W];
        end
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign out_data = out_valid ? acc : '0;
  assign out_ovf  = out_valid ? ovf : 1'b0;
  assign out_cnt  = out_valid ? cnt : '0;

endmodule

// File: tb/tb_accum_frame4.sv
// Scoreboard bench for accum_frame4: a reference model pushes expected frame
// results as beats are accepted; the output monitor pops and compares them.
module tb_accum_frame4;

  localparam int IN_W  = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 4;
  localparam int unsigned ACC_MOD = 256;
  localparam int unsigned CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;
  logic [CNT_W-1:0] out_cnt;

  typedef struct {
    int unsigned d;
    int unsigned o;
    int unsigned c;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned m_acc = 0;
  int unsigned m_cnt = 0;
  int unsigned m_ovf = 0;

  accum_frame4 #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Output monitor: compares the head result every HOLD cycle (stability), pops on handshake.
  always @(negedge clk) begin
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        chk("out_data", out_data, exp_q[0].d);
        chk("out_ovf",  out_ovf,  exp_q[0].o);
        chk("out_cnt",  out_cnt,  exp_q[0].c);
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("idle_zero", {out_data, out_ovf, out_cnt}, 0);
    end
  end

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic beat(input int unsigned d, input bit last);
    int unsigned guard = 0;
    int unsigned s;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = IN_W'(d);
    in_last  = last;
    #1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    if (m_cnt == 0) begin
      m_acc = d;
      m_ovf = 0;
    end else begin
      s = m_acc + d;
      if (s >= ACC_MOD) m_ovf = 1;
      m_acc = s % ACC_MOD;
    end
    if (m_cnt < CNT_MAX) m_cnt++;
    if (last) begin
      e.d = m_acc;
      e.o = m_ovf;
      e.c = m_cnt;
      exp_q.push_back(e);
      model_clear();
      @(posedge clk);
      #1;
      chk("latency", out_valid, 1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"},  out_data,  0);
    chk({tag, "_ovf"},   out_ovf,   0);
    chk({tag, "_cnt"},   out_cnt,   0);
    chk({tag, "_ready"}, in_ready,  0);
  endtask

  initial begin
    #2;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic four-beat frame
    beat(3, 0); beat(5, 0); beat(7, 0); beat(15, 1);
    idle();
    drain();

    // Overflow and count saturation
    for (int i = 0; i < 18; i++) beat(15, i == 17);
    idle();
    drain();

    // Back-pressure in HOLD
    out_ready = 1'b0;
    beat(2, 0); beat(6, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = IN_W'(11);
      in_last  = 1'b0;
      #1;
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", out_valid, 0);
    beat(9, 1);
    idle();
    drain();

    // clr aborts a partial frame and wins over a simultaneous beat
    beat(4, 0); beat(4, 0);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = IN_W'(6); in_last = 1'b0;
    #1;
    chk("clr_in_ready", in_ready, 0);
    model_clear();
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    beat(2, 1);
    idle();
    drain();

    // clr ignored in HOLD
    out_ready = 1'b0;
    beat(8, 1);
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    out_ready = 1'b1;
    drain();

    // Async reset mid-frame
    beat(5, 0); beat(5, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    model_clear();
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Async reset in HOLD drops the pending result
    out_ready = 1'b0;
    beat(7, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("rst_hold");
    model_clear();
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    beat(1, 0); beat(1, 1);
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
